// File: rtl/weights_loader_pkg.sv
// Shared constants and FSM encoding for the weights fill path.
// The RAM weights array is sized from the same constants.
package weights_loader_pkg;
  localparam int WORD_W    = 21;
  localparam int ADDR_W    = 24;
  localparam int CNT_W     = 18;
  localparam int MAX_WORDS = 210852;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_t;
endpackage

// File: rtl/byte_packer.sv
// Little-endian 3-byte assembler; word_valid pulses on the
// phase-2 accept with the full 24-bit word presented alongside.
module byte_packer (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [23:0] word
);
  logic [1:0]  phase_q;
  logic [15:0] asm_q;

  // top byte is forwarded live so the word is complete on the accept
  assign word_valid = accept && (phase_q == 2'd2);
  assign word       = {byte_in, asm_q};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      asm_q   <= '0;
    end else if (clr) begin
      phase_q <= 2'd0;
      asm_q   <= '0;
    end else if (accept) begin
      phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      if (phase_q == 2'd0) asm_q[7:0]  <= byte_in;
      if (phase_q == 2'd1) asm_q[15:8] <= byte_in;
    end
  end
endmodule

// File: rtl/weights_loader.sv
// Byte-stream to weights RAM fill stage: packs 3 bytes per word
// and drives the RAM weights write port.
module weights_loader #(
  parameter int WORD_W    = weights_loader_pkg::WORD_W,
  parameter int ADDR_W    = weights_loader_pkg::ADDR_W,
  parameter int CNT_W     = weights_loader_pkg::CNT_W,
  parameter int MAX_WORDS = weights_loader_pkg::MAX_WORDS
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we_weights,
  output logic [ADDR_W-1:0] address_in_weights,
  output logic [WORD_W-1:0] data_in_weights,
  output logic              busy,
  output logic              done,
  output logic              err_sign,
  output logic              err_range
);
  import weights_loader_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q, idx_q;
  logic              accept, word_valid, last_word;
  logic              range_bad, take_start, clr;
  logic [23:0]       word;

  // one extra bit so the bound check itself cannot wrap
  assign range_bad = ({1'b0, base_addr} + (ADDR_W+1)'(word_count))
                     > (ADDR_W+1)'(MAX_WORDS);
  assign take_start = (state_q == S_IDLE) && start;
  assign clr        = take_start && !range_bad && (word_count != '0);
  assign accept     = byte_valid && byte_ready;
  assign last_word  = (idx_q == cnt_q - 1'b1);

  byte_packer u_packer (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .clr        (clr),
    .accept     (accept),
    .byte_in    (byte_in),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !range_bad)
          state_d = (word_count == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid && last_word) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      base_q             <= '0;
      cnt_q              <= '0;
      idx_q              <= '0;
      we_weights         <= 1'b0;
      address_in_weights <= '0;
      data_in_weights    <= '0;
      err_sign           <= 1'b0;
      err_range          <= 1'b0;
    end else begin
      we_weights <= word_valid;
      if (take_start) err_range <= range_bad;
      if (clr) begin
        base_q   <= base_addr;
        cnt_q    <= word_count;
        idx_q    <= '0;
        err_sign <= 1'b0;
      end
      if (word_valid) begin
        address_in_weights <= base_q + ADDR_W'(idx_q);
        data_in_weights    <= word[WORD_W-1:0];
        idx_q              <= idx_q + 1'b1;
        // upper byte bits must be a sign extension of the weight
        if (word[23:WORD_W] != {(24-WORD_W){word[WORD_W-1]}})
          err_sign <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_weights_loader.sv
// Directed and table-driven bench for weights_loader.
// Writes are captured at negedge into a queue for later checks.
module tb_weights_loader;
  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] base_addr;
  logic [17:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we_weights;
  logic [23:0] address_in_weights;
  logic [20:0] data_in_weights;
  logic        busy;
  logic        done;
  logic        err_sign;
  logic        err_range;

  weights_loader dut (
    .clk_in             (clk_in),
    .rst_n              (rst_n),
    .start              (start),
    .base_addr          (base_addr),
    .word_count         (word_count),
    .byte_in            (byte_in),
    .byte_valid         (byte_valid),
    .byte_ready         (byte_ready),
    .we_weights         (we_weights),
    .address_in_weights (address_in_weights),
    .data_in_weights    (data_in_weights),
    .busy               (busy),
    .done               (done),
    .err_sign           (err_sign),
    .err_range          (err_range)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [23:0] a;
    logic [20:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [20:0] exp_d;
    logic        exp_s;
  } vec_t;

  wr_t  wq[$];
  int   rdy_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  vec_t vt[7];
  logic [7:0]  bq[150];
  logic [20:0] exp_w[50];

  always @(negedge clk_in) begin
    if (we_weights) wq.push_back('{address_in_weights, data_in_weights});
    if (byte_ready) rdy_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start(input logic [23:0] b, input logic [17:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick;
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      tick;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int rb;
    vt[0] = '{8'h01, 8'h00, 8'h00, 21'h000001, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 21'h1FFFFF, 1'b0};
    vt[2] = '{8'h00, 8'h00, 8'h20, 21'h000000, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 8'hEF, 21'h0FFFFF, 1'b1};
    vt[4] = '{8'h34, 8'h12, 8'h10, 21'h101234, 1'b1};
    vt[5] = '{8'h56, 8'h34, 8'hF2, 21'h123456, 1'b0};
    vt[6] = '{8'hAB, 8'hCD, 8'h0E, 21'h0ECDAB, 1'b0};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) tick;
    chk("rst_flags",
        {26'd0, byte_ready, we_weights, busy, done, err_sign, err_range},
        32'd0);
    chk("rst_addr", 32'(address_in_weights), 32'd0);
    chk("rst_data", 32'(data_in_weights), 32'd0);
    rst_n = 1'b1;
    tick;

    // two words back to back, exact cycle timing
    do_start(24'd0, 18'd2);
    chk("t1_busy", {30'd0, busy, byte_ready}, 32'd3);
    put_byte(8'h01); put_byte(8'h00); put_byte(8'h00);
    chk("t1_w0", {7'd0, we_weights, address_in_weights}, {7'd0, 1'b1, 24'd0});
    chk("t1_d0", 32'(data_in_weights), 32'h000001);
    chk("t1_rdy0", 32'(byte_ready), 32'd1);
    put_byte(8'hFF); put_byte(8'hFF); put_byte(8'hFF);
    chk("t1_w1", {7'd0, we_weights, address_in_weights}, {7'd0, 1'b1, 24'd1});
    chk("t1_d1", 32'(data_in_weights), 32'h1FFFFF);
    chk("t1_rdy1", 32'(byte_ready), 32'd0);
    chk("t1_sign", 32'(err_sign), 32'd0);
    tick;
    chk("t1_done", {30'd0, done, busy}, 32'd2);
    tick;
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_nwr", wq.size(), 32'd2);
    wq.delete();

    // single-word vectors
    foreach (vt[i]) begin
      do_start(24'(200 + i), 18'd1);
      put_byte(vt[i].b0); put_byte(vt[i].b1); put_byte(vt[i].b2);
      chk("vec_we", 32'(we_weights), 32'd1);
      chk("vec_addr", 32'(address_in_weights), 32'(200 + i));
      chk("vec_data", 32'(data_in_weights), 32'(vt[i].exp_d));
      chk("vec_sign", 32'(err_sign), 32'(vt[i].exp_s));
      tick;
      chk("vec_done", 32'(done), 32'd1);
      tick;
    end
    chk("vec_nwr", wq.size(), 32'd7);
    wq.delete();

    // out-of-range start is rejected
    do_start(24'd210850, 18'd3);
    chk("rng_err", {30'd0, err_range, busy}, 32'd2);
    repeat (3) tick;
    chk("rng_idle", {30'd0, busy, byte_ready}, 32'd0);
    chk("rng_nwr", wq.size(), 32'd0);

    // zero-count start clears err_range and completes at once
    rb = rdy_cnt;
    do_start(24'd0, 18'd0);
    chk("z_done", {29'd0, done, busy, err_range}, 32'd4);
    tick;
    chk("z_done_off", 32'(done), 32'd0);
    tick;
    chk("z_rdy", rdy_cnt - rb, 32'd0);
    chk("z_nwr", wq.size(), 32'd0);

    // last legal word in the RAM
    do_start(24'd210851, 18'd1);
    chk("edge_ok", {30'd0, err_range, busy}, 32'd1);
    put_byte(8'h05); put_byte(8'h06); put_byte(8'h07);
    chk("edge_addr", 32'(address_in_weights), 32'd210851);
    chk("edge_data", 32'(data_in_weights), 32'h070605);
    wait_done(5);
    tick;
    wq.delete();

    // 50 words with random gaps and ignored starts
    for (int j = 0; j < 150; j++) bq[j] = 8'($urandom);
    for (int w = 0; w < 50; w++)
      exp_w[w] = {bq[3*w+2][4:0], bq[3*w+1], bq[3*w]};
    do_start(24'd1000, 18'd50);
    for (int j = 0; j < 150; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          start      = ($urandom_range(0, 2) == 0);
          base_addr  = 24'd210852;
          word_count = 18'd5;
          tick;
          start = 1'b0;
        end
      end
      put_byte(bq[j]);
    end
    wait_done(10);
    chk("rnd_nwr", wq.size(), 32'd50);
    chk("rnd_rng", 32'(err_range), 32'd0);
    for (int w = 0; w < 50 && w < wq.size(); w++) begin
      chk("rnd_addr", 32'(wq[w].a), 32'(1000 + w));
      chk("rnd_data", 32'(wq[w].d), 32'(exp_w[w]));
    end
    tick;
    wq.delete();

    // reset mid-load
    do_start(24'd20, 18'd3);
    put_byte(8'h0A); put_byte(8'h0B); put_byte(8'h0C); put_byte(8'h0D);
    rst_n = 1'b0;
    #1;
    chk("mr_nwr", wq.size(), 32'd1);
    if (wq.size() > 0) chk("mr_w0", 32'(wq[0].d), 32'h0C0B0A);
    chk("mr_flags",
        {26'd0, byte_ready, we_weights, busy, done, err_sign, err_range},
        32'd0);
    chk("mr_out", 32'(address_in_weights) | 32'(data_in_weights), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    repeat (4) tick;
    chk("mr_nowr", wq.size(), 32'd1);
    chk("mr_idle", 32'(busy), 32'd0);
    do_start(24'd10, 18'd1);
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h03);
    chk("mr_addr", 32'(address_in_weights), 32'd10);
    chk("mr_data", 32'(data_in_weights), 32'h032211);
    wait_done(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
